// File: rtl/fifo_word_packer.sv
// Packs RATIO show-ahead FIFO words into one little-endian wide word on a valid/ready output.
// Optional idle-timeout flush of partial words: define PACKER_TIMEOUT_EN.
module fifo_word_packer #(
    parameter int DATAWIDTH = 8,
    parameter int RATIO     = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATAWIDTH-1:0]       fifo_data,
    input  logic                       fifo_empty,
    output logic                       fifo_rd,
    input  logic                       flush,
    output logic [DATAWIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]           out_keep,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                word_count
);

    localparam int CW = $clog2(RATIO) + 1;

    if (RATIO < 2 || TIMEOUT < 1) begin : g_param_check
        $error("fifo_word_packer: RATIO must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                     state_q;
    logic [CW-1:0]              cnt_q;
    logic [DATAWIDTH*RATIO-1:0] asm_q, asm_d;
    logic [RATIO-1:0]           keep_q, keep_d;
    logic [DATAWIDTH*RATIO-1:0] out_data_q;
    logic [RATIO-1:0]           out_keep_q;
    logic                       out_valid_q;
    logic [31:0]                word_count_q;
    logic                       last_lane;
    logic                       flush_eff;
    logic                       tmo_fire;

`ifdef PACKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    logic [TW-1:0] tmo_q;
    assign tmo_fire = (state_q == FILL) && (tmo_q == TW'(TIMEOUT));
`else
    assign tmo_fire = 1'b0;
`endif

    assign fifo_rd   = !reset && !fifo_empty &&
                       ((state_q == FILL) || ((state_q == HOLD) && out_ready));
    assign last_lane = (cnt_q == CW'(RATIO - 1));
    assign flush_eff = flush || tmo_fire;

    // Assembly register with the head word merged into lane cnt; used only when a pop happens.
    always_comb begin
        asm_d  = asm_q;
        keep_d = keep_q;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (cnt_q == i[CW-1:0]) begin
                asm_d[i*DATAWIDTH +: DATAWIDTH] = fifo_data;
                keep_d[i]                       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FILL;
            cnt_q        <= '0;
            asm_q        <= '0;
            keep_q       <= '0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_valid_q  <= 1'b0;
            word_count_q <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (fifo_rd && last_lane) begin
                        out_data_q  <= asm_d;
                        out_keep_q  <= '1;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                        cnt_q       <= '0;
                        asm_q       <= '0;
                        keep_q      <= '0;
                    end else if (flush_eff && (fifo_rd || cnt_q != '0)) begin
                        out_data_q  <= fifo_rd ? asm_d : asm_q;
                        out_keep_q  <= fifo_rd ? keep_d : keep_q;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                        cnt_q       <= '0;
                        asm_q       <= '0;
                        keep_q      <= '0;
                    end else if (fifo_rd) begin
                        asm_q  <= asm_d;
                        keep_q <= keep_d;
                        cnt_q  <= cnt_q + CW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        word_count_q <= word_count_q + 32'd1;
                        out_valid_q  <= 1'b0;
                        state_q      <= FILL;
                        // Assembly is already empty here, so a pop lands in lane 0.
                        if (fifo_rd) begin
                            asm_q  <= asm_d;
                            keep_q <= keep_d;
                            cnt_q  <= CW'(1);
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

`ifdef PACKER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset || fifo_rd || tmo_fire || state_q == HOLD || cnt_q == '0) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TW'(1);
        end
    end
`endif

    assign out_data   = out_data_q;
    assign out_keep   = out_keep_q;
    assign out_valid  = out_valid_q;
    assign word_count = word_count_q;

endmodule
